// File: rtl/mips_pkg.sv
// Shared constants and the IF/ID record for the MIPS pipeline stages.
package mips_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/registro_if_id.sv
// IF/ID pipeline register: reset > flush > stall > load, with NOP injection on
// reset and flush so a squashed slot never reaches decode as a real instruction.
module registro_if_id #(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     instr_i,
  input  logic [31:0]     pc4_i,
  output mips_pkg::if_id_t if_id_o
);
  import mips_pkg::*;

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Flush beats stall: a wrong-path bubble must not be held in place.
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.instr = NOP_WORD;
      if_id_d.pc4   = pc4_i;
      if_id_d.valid = 1'b0;
    end else if (!stall) begin
      if_id_d.instr = instr_i;
      if_id_d.pc4   = pc4_i;
      if_id_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q.instr <= NOP_WORD;
      if_id_q.pc4   <= 32'd0;
      if_id_q.valid <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, and feeds the
// IF/ID register; also counts accepted instructions and flags misaligned targets.
module etapa_fetch #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);
  import mips_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;
  logic        load_valid;
  if_id_t      if_id;

  assign pc_plus4   = pc_q + PC_STEP;
  assign load_valid = !flush && !stall;

  // Redirect outranks stall so a taken branch is never lost behind a bubble.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_en) begin
      pc_d = align_word(redirect_pc);
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    count_d    = load_valid ? count_q + 32'd1 : count_q;
    misalign_d = misalign_q | (redirect_en && (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      count_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  registro_if_id #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .flush   (flush),
    .instr_i (imem_instr),
    .pc4_i   (pc_plus4),
    .if_id_o (if_id)
  );

  assign imem_addr    = pc_q;
  assign if_id_instr  = if_id.instr;
  assign if_id_pc4    = if_id.pc4;
  assign if_id_valid  = if_id.valid;
  assign fetch_count  = count_q;
  assign misalign_err = misalign_q;

endmodule
